// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, WIDTH+1-bit result with done pulse.
// Optional signed-overflow output built only when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   sum
`ifdef SERIAL_ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic                 carry_q, carry_d;
   logic                 sub_q, sub_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic [WIDTH:0]       sum_q, sum_d;
   logic [DIGIT:0]       dsum;
   logic [WIDTH+DIGIT-1:0] res_cat;
   logic                 last;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic                 ovf_q, ovf_d;
`endif

   // One digit of the ripple: B is already inverted for subtraction.
   assign dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
   assign res_cat = {dsum[DIGIT-1:0], res_q};
   assign last    = (cnt_q == CW'(N - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B ^ {WIDTH{sub}};
               carry_d = cin ^ sub;
               sub_d   = sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dsum[DIGIT];
            res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
            if (last) begin
               // Subtraction reports borrow, the complement of the final carry.
               sum_d   = {sub_q ^ dsum[DIGIT], res_cat[WIDTH+DIGIT-1:DIGIT]};
`ifdef SERIAL_ADDSUB_OVF_EN
               // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
               ovf_d   = (a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1]) ^ dsum[DIGIT];
`endif
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         sum_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign sum  = sum_q;
`ifdef SERIAL_ADDSUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
